// File: rtl/jam_param.sv
// Job-assignment engine: tries every one-to-one worker/job assignment,
// sums the costs read from an external 1-cycle-latency cost ROM, and
// reports the minimum or maximum total and how many assignments hit it.
module jam_param #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Mode,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic              Busy,
  output logic              Valid,
  output logic [SUM_W-1:0]  OptCost,
  output logic [CNT_W-1:0]  MatchCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_COMPARE, S_NEXTPERM, S_DONE
  } state_t;

  // k counts FETCH cycles 0..N; cost for address k-1 arrives when k>=1
  localparam int K_W = $clog2(N + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   perm_q [N];
  logic [IDX_W-1:0]   perm_d [N];
  logic [IDX_W-1:0]   np_perm [N];
  logic               np_last;
  logic [K_W-1:0]     k_q, k_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   best_q, best_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               has_best_q, has_best_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   opt_q, opt_d;
  logic [CNT_W-1:0]   match_q, match_d;

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign OptCost    = opt_q;
  assign MatchCount = match_q;

  // Lexicographic successor of perm_q: rightmost ascent pivot, swap with the
  // rightmost larger element, then reverse the suffix. Only constant indices
  // are used so the whole step is a single cycle of muxes.
  always_comb begin
    int               p;
    int               s;
    logic [IDX_W-1:0] pv;
    logic [IDX_W-1:0] sv;
    logic [IDX_W-1:0] sw [N];
    p = -1;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) p = i;
    end
    pv = '0;
    for (int i = 0; i < N; i++) begin
      if (i == p) pv = perm_q[i];
    end
    s  = N - 1;
    sv = '0;
    for (int i = 0; i < N; i++) begin
      if (i > p && perm_q[i] > pv) begin
        s  = i;
        sv = perm_q[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == p)      sw[i] = sv;
      else if (i == s) sw[i] = pv;
      else             sw[i] = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      np_perm[i] = sw[i];
      for (int m = 0; m < N; m++) begin
        if (i > p && m == N + p - i) np_perm[i] = sw[m];
      end
    end
    np_last = (p < 0);
  end

  // Next-state and datapath decode for the run controller
  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can leave one
    // unassigned and infer a latch.
    state_d    = state_q;
    perm_d     = perm_q;
    k_d        = k_q;
    sum_d      = sum_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    has_best_d = has_best_q;
    mode_d     = mode_q;
    w_d        = w_q;
    j_d        = j_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    opt_d      = opt_q;
    match_d    = match_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          mode_d  = Mode;
        end
      end
      S_INIT: begin
        for (int i = 0; i < N; i++) perm_d[i] = IDX_W'(i);
        has_best_d = 1'b0;
        best_d     = '0;
        cnt_d      = '0;
        sum_d      = '0;
        k_d        = '0;
        w_d        = '0;
        j_d        = '0;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (k_q != '0) sum_d = sum_q + SUM_W'(Cost);
        for (int i = 1; i < N; i++) begin
          if (int'(k_q) + 1 == i) begin
            w_d = IDX_W'(i);
            j_d = perm_q[i];
          end
        end
        if (int'(k_q) == N) state_d = S_COMPARE;
        else                k_d     = k_q + 1'b1;
      end
      S_COMPARE: begin
        if (!has_best_q || (mode_q ? (sum_q > best_q) : (sum_q < best_q))) begin
          best_d     = sum_q;
          cnt_d      = CNT_W'(1);
          has_best_d = 1'b1;
        end else if (sum_q == best_q) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = S_NEXTPERM;
      end
      S_NEXTPERM: begin
        if (np_last) begin
          state_d = S_DONE;
        end else begin
          perm_d  = np_perm;
          sum_d   = '0;
          k_d     = '0;
          w_d     = '0;
          j_d     = np_perm[0];
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        opt_d   = best_q;
        match_d = cnt_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers, synchronously reset
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others.
    if (RST) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      sum_q      <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
      has_best_q <= 1'b0;
      mode_q     <= 1'b0;
      w_q        <= '0;
      j_q        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      opt_q      <= '0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sum_q      <= sum_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
      has_best_q <= has_best_d;
      mode_q     <= mode_d;
      w_q        <= w_d;
      j_q        <= j_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      opt_q      <= opt_d;
      match_q    <= match_d;
    end
  end

  // Permutation register
  always_ff @(posedge CLK) begin
    // NOTE: perm_q has no reset; INIT always loads it before it is read.
    perm_q <= perm_d;
  end

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param: three instances (N=3, 4, 6) each beside a 1-cycle
// latency cost ROM model; expected results come from constant tables and a
// brute-force software search over all index tuples.
`timescale 1ns/1ps
module tb_jam_param;

  typedef enum int {P_EX3, P_ONES, P_DIAG, P_WPJ, P_127, P_RAND} pat_t;

  typedef struct {
    int    dut;
    logic  mode;
    int    pat;
    int    opt;
    int    cnt;
    string name;
  } vec_t;

  typedef struct {
    int    opt;
    int    cnt;
    string name;
  } exp_t;

  localparam int NV = 10;
  localparam int NN  [3] = '{3, 4, 6};
  localparam int LIM [3] = '{50, 200, 7208};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a [3];
  logic       mode_a  [3];
  logic [6:0] mem [3][8][8];
  int         rand_tbl [8][8];
  int         ex3 [3][3] = '{'{5, 9, 1}, '{10, 3, 2}, '{8, 7, 4}};

  logic [2:0] w3, j3, w4, j4, w6, j6;
  logic [6:0] c3, c4, c6;
  logic       busy3, busy4, busy6, valid3, valid4, valid6;
  logic [9:0] opt3, opt4, opt6;
  logic [15:0] cnt3, cnt4, cnt6;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   wj_err  = 0;
  exp_t sb [$];
  vec_t vecs [NV];

  always #5 clk = ~clk;

  jam_param #(.N(3), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) u_n3 (
    .CLK(clk), .RST(rst), .Start(start_a[0]), .Mode(mode_a[0]),
    .W(w3), .J(j3), .Cost(c3), .Busy(busy3), .Valid(valid3),
    .OptCost(opt3), .MatchCount(cnt3));

  jam_param #(.N(4), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) u_n4 (
    .CLK(clk), .RST(rst), .Start(start_a[1]), .Mode(mode_a[1]),
    .W(w4), .J(j4), .Cost(c4), .Busy(busy4), .Valid(valid4),
    .OptCost(opt4), .MatchCount(cnt4));

  jam_param #(.N(6), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) u_n6 (
    .CLK(clk), .RST(rst), .Start(start_a[2]), .Mode(mode_a[2]),
    .W(w6), .J(j6), .Cost(c6), .Busy(busy6), .Valid(valid6),
    .OptCost(opt6), .MatchCount(cnt6));

  // Cost ROMs: address captured at one edge, data visible before the next
  always @(posedge clk) begin
    c3 <= mem[0][w3][j3];
    c4 <= mem[1][w4][j4];
    c6 <= mem[2][w6][j6];
  end

  // Index range monitor while a run is in progress
  always @(negedge clk) begin
    if (!rst) begin
      if (busy3 && (w3 >= 3'd3 || j3 >= 3'd3)) wj_err++;
      if (busy4 && (w4 >= 3'd4 || j4 >= 3'd4)) wj_err++;
      if (busy6 && (w6 >= 3'd6 || j6 >= 3'd6)) wj_err++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] get_busy(input int idx);
    case (idx)
      0: return 32'(busy3);
      1: return 32'(busy4);
      default: return 32'(busy6);
    endcase
  endfunction

  function automatic logic [31:0] get_valid(input int idx);
    case (idx)
      0: return 32'(valid3);
      1: return 32'(valid4);
      default: return 32'(valid6);
    endcase
  endfunction

  function automatic logic [31:0] get_opt(input int idx);
    case (idx)
      0: return 32'(opt3);
      1: return 32'(opt4);
      default: return 32'(opt6);
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int idx);
    case (idx)
      0: return 32'(cnt3);
      1: return 32'(cnt4);
      default: return 32'(cnt6);
    endcase
  endfunction

  function automatic logic [31:0] get_w(input int idx);
    case (idx)
      0: return 32'(w3);
      1: return 32'(w4);
      default: return 32'(w6);
    endcase
  endfunction

  function automatic logic [31:0] get_j(input int idx);
    case (idx)
      0: return 32'(j3);
      1: return 32'(j4);
      default: return 32'(j6);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_table(input int idx, input int pat);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (pat)
          P_EX3:   mem[idx][w][j] = (w < 3 && j < 3) ? 7'(ex3[w][j]) : 7'd0;
          P_ONES:  mem[idx][w][j] = 7'd1;
          P_DIAG:  mem[idx][w][j] = (w == j) ? 7'd0 : 7'd10;
          P_WPJ:   mem[idx][w][j] = 7'(w + j);
          P_127:   mem[idx][w][j] = 7'd127;
          default: mem[idx][w][j] = 7'(rand_tbl[w][j]);
        endcase
      end
    end
  endtask

  // Brute force over every n-tuple of job indices, keeping only those with
  // all jobs distinct.
  task automatic golden(input int n, output int mn, output int mnc,
                        output int mx, output int mxc);
    int total;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    mn = 1 << 30; mnc = 0; mx = -1; mxc = 0;
    for (int t = 0; t < total; t++) begin
      int x;
      int used;
      int s;
      bit ok;
      x = t; used = 0; s = 0; ok = 1'b1;
      for (int w = 0; w < n; w++) begin
        int jj;
        jj = x % n;
        x  = x / n;
        if (used[jj]) ok = 1'b0;
        used |= (1 << jj);
        s += rand_tbl[w][jj];
      end
      if (ok) begin
        if (s < mn) begin mn = s; mnc = 1; end
        else if (s == mn) mnc++;
        if (s > mx) begin mx = s; mxc = 1; end
        else if (s == mx) mxc++;
      end
    end
  endtask

  task automatic run_vec(input int idx, input logic md, input int exp_opt,
                         input int exp_cnt, input string name);
    exp_t e;
    int   cyc;
    e.opt = exp_opt; e.cnt = exp_cnt; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start_a[idx] = 1'b1;
    mode_a[idx]  = md;
    @(negedge clk);
    start_a[idx] = 1'b0;
    check({name, " busy_after_start"}, get_busy(idx), 32'd1);
    check({name, " valid_drop"}, get_valid(idx), 32'd0);
    cyc = 1;
    while (get_valid(idx) !== 32'd1 && cyc < LIM[idx]) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done_in_bound"}, get_valid(idx), 32'd1);
    e = sb.pop_front();
    check({e.name, " opt"}, get_opt(idx), 32'(e.opt));
    check({e.name, " cnt"}, get_cnt(idx), 32'(e.cnt));
    check({e.name, " busy_clear"}, get_busy(idx), 32'd0);
  endtask

  initial begin
    int gmn, gmnc, gmx, gmxc;
    int cyc;
    int busy_gaps;

    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      mode_a[i]  = 1'b0;
      load_table(i, P_ONES);
    end
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        rand_tbl[w][j] = int'($urandom_range(0, 127));
    golden(6, gmn, gmnc, gmx, gmxc);

    vecs[0] = '{0, 1'b0, P_EX3,  12,   2,    "n3_min"};
    vecs[1] = '{0, 1'b1, P_EX3,  23,   1,    "n3_max"};
    vecs[2] = '{1, 1'b0, P_ONES, 4,    24,   "n4_ones"};
    vecs[3] = '{1, 1'b0, P_DIAG, 0,    1,    "n4_diag_min"};
    vecs[4] = '{1, 1'b1, P_DIAG, 40,   9,    "n4_diag_max"};
    vecs[5] = '{2, 1'b0, P_WPJ,  30,   720,  "n6_wpj_min"};
    vecs[6] = '{2, 1'b1, P_WPJ,  30,   720,  "n6_wpj_max"};
    vecs[7] = '{2, 1'b0, P_127,  762,  720,  "n6_all127"};
    vecs[8] = '{2, 1'b0, P_RAND, gmn,  gmnc, "n6_rand_min"};
    vecs[9] = '{2, 1'b1, P_RAND, gmx,  gmxc, "n6_rand_max"};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_busy%0d", NN[i]),  get_busy(i),  32'd0);
      check($sformatf("reset_valid%0d", NN[i]), get_valid(i), 32'd0);
      check($sformatf("reset_opt%0d", NN[i]),   get_opt(i),   32'd0);
      check($sformatf("reset_cnt%0d", NN[i]),   get_cnt(i),   32'd0);
      check($sformatf("reset_w%0d", NN[i]),     get_w(i),     32'd0);
      check($sformatf("reset_j%0d", NN[i]),     get_j(i),     32'd0);
    end

    // Table-driven runs
    for (int v = 0; v < NV; v++) begin
      load_table(vecs[v].dut, vecs[v].pat);
      run_vec(vecs[v].dut, vecs[v].mode, vecs[v].opt, vecs[v].cnt, vecs[v].name);
    end

    // Start held high for a whole run: one run only, then a pulse restarts
    load_table(0, P_EX3);
    @(negedge clk);
    start_a[0] = 1'b1;
    mode_a[0]  = 1'b0;
    @(negedge clk);
    cyc = 1;
    busy_gaps = 0;
    while (valid3 !== 1'b1 && cyc < LIM[0]) begin
      if (busy3 !== 1'b1) busy_gaps++;
      @(negedge clk);
      cyc++;
    end
    start_a[0] = 1'b0;
    check("hold_done_in_bound", 32'(valid3), 32'd1);
    check("hold_busy_continuous", 32'(busy_gaps), 32'd0);
    check("hold_opt", 32'(opt3), 32'd12);
    check("hold_cnt", 32'(cnt3), 32'd2);
    @(negedge clk);
    check("hold_no_second_run", 32'(busy3), 32'd0);
    check("hold_valid_kept", 32'(valid3), 32'd1);
    run_vec(0, 1'b1, 23, 1, "hold_restart");

    // Reset in the middle of a run aborts it with no result
    load_table(1, P_DIAG);
    @(negedge clk);
    start_a[1] = 1'b1;
    mode_a[1]  = 1'b0;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (49) @(negedge clk);
    check("midrun_busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  32'(busy4), 32'd0);
    check("abort_valid", 32'(valid4), 32'd0);
    check("abort_opt",   32'(opt4), 32'd0);
    check("abort_cnt",   32'(cnt4), 32'd0);
    repeat (200) @(negedge clk);
    check("abort_no_result", 32'(valid4), 32'd0);
    run_vec(1, 1'b1, 40, 9, "after_abort");

    check("wj_range", 32'(wj_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
